// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the instruction loader
package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_DONE,
    ST_ERROR,
    ST_CHK
  } loader_state_t;

  localparam int   LEN_BYTES   = 2;
  localparam int   WORD_BYTES  = 3;
  localparam logic HOLD_ACTIVE = 1'b1;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian bytes into one instruction word, flags a non-zero top nibble
module word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 20,
  parameter int BYTES_PER_WORD = WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_ready,
  output logic                  overflow
);

  localparam int         TOP_BITS = DATA_WIDTH - 16;
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]            idx_q, idx_d;
  logic [7:0]            lane0_q, lane0_d;
  logic [7:0]            lane1_q, lane1_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  ready_q, ready_d;

  always_comb begin
    idx_d    = idx_q;
    lane0_d  = lane0_q;
    lane1_d  = lane1_q;
    word_d   = word_q;
    ready_d  = 1'b0;
    overflow = 1'b0;
    if (clear) begin
      idx_d   = '0;
      lane0_d = '0;
      lane1_d = '0;
      word_d  = '0;
    end else if (byte_valid) begin
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        overflow = |byte_data[7:TOP_BITS];
        // A rejected word leaves the previous word on the output untouched.
        if (!overflow) begin
          word_d  = {byte_data[TOP_BITS-1:0], lane1_q, lane0_q};
          ready_d = 1'b1;
        end
      end else begin
        if (idx_q == 2'd0) lane0_d = byte_data;
        else               lane1_d = byte_data;
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      lane0_q <= '0;
      lane1_q <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

  assign word       = word_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - fills instruction memory from a length-prefixed byte stream, holding the CPU until loaded
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum byte is verified in a CHK state before DONE.
module instr_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 20,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int MEM_SIZE       = 256,
  parameter int BYTES_PER_WORD = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH:0]   word_count
);

  localparam int               LEN_W      = LEN_BYTES * 8;
  localparam logic [LEN_W-1:0] MEM_SIZE_N = LEN_W'(MEM_SIZE);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t    END_STATE  = ST_CHK;
`else
  localparam loader_state_t    END_STATE  = ST_DONE;
`endif

  loader_state_t            state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [LEN_W-1:0]         len_new;
  logic                     hs;
  logic                     asm_clear;
  logic                     asm_valid;
  logic                     asm_ready;
  logic                     asm_overflow;
  logic [DATA_WIDTH-1:0]    asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               chk_q, chk_d;
`endif

  word_assembler #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_data  (in_data),
    .word       (asm_word),
    .word_ready (asm_ready),
    .overflow   (asm_overflow)
  );

  always_comb begin
    case (state_q)
      ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:                                    in_ready = 1'b1;
`endif
      default:                                   in_ready = 1'b0;
    endcase
  end

  assign hs      = in_valid && in_ready;
  assign len_new = {in_data, len_q[7:0]};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    count_d   = count_q;
    asm_clear = 1'b0;
    asm_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_LEN_LO;
          len_d     = '0;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (hs) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (hs) begin
          len_d = len_new;
          if (len_new == '0)             state_d = END_STATE;
          else if (len_new > MEM_SIZE_N) state_d = ST_ERROR;
          else                           state_d = ST_B0;
        end
      end
      ST_B0, ST_B1, ST_B2: begin
        if (hs) begin
          asm_valid = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d     = chk_q ^ in_data;
`endif
          if (state_q == ST_B0)      state_d = ST_B1;
          else if (state_q == ST_B1) state_d = ST_B2;
          else if (asm_overflow)     state_d = ST_ERROR;
          else                       state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        // The address only advances when another word follows, so it never wraps.
        if (LEN_W'(count_d) == len_q) begin
          state_d = END_STATE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_B0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (hs) state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end
`endif

  assign imem_we    = (state_q == ST_WRITE) && asm_ready;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_word;
  assign cpu_hold   = (state_q == ST_DONE) ? ~HOLD_ACTIVE : HOLD_ACTIVE;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign word_count = count_q;

endmodule
